multi_shift_reg: RTL and testbench

//  Parametrised successor shift register for the divider datapath and related arithmetic units.

---
 rtl/multi_shift_reg_pkg.sv | 19 +
 rtl/multi_shift_reg_if.sv | 41 ++++
 rtl/multi_shift_reg_step.sv | 49 ++++
 rtl/multi_shift_reg.sv | 137 +++++++++++++
 tb/tb_multi_shift_reg.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multi_shift_reg_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Shared constants for the multi_shift_reg slice.
//   MODE_LOG / MODE_ARI / MODE_ROT : shift mode encodings (2'b11 behaves as
//                                    logical)
//   state_t                        : multi-step engine states
// -----------------------------------------------------------------------------
package shift_pkg;

    localparam logic [1:0] MODE_LOG = 2'b00;
    localparam logic [1:0] MODE_ARI = 2'b01;
    localparam logic [1:0] MODE_ROT = 2'b10;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/multi_shift_reg_if.sv
// -----------------------------------------------------------------------------
// multi_shift_reg_if
// Control/data bundle of the shift register.
//   In, load, clr          : parallel load and synchronous clear
//   sl, sr, shiftIn, mode  : single-step shift controls
//   start, dir, amt        : multi-step request
//   out, shift_out         : register contents and last bit shifted out
//   busy, done             : multi-step status
// master drives the controls, slave is the shift register.
// -----------------------------------------------------------------------------
interface multi_shift_reg_if #(
    parameter int NBIT = 16,
    parameter int AW   = $clog2(NBIT + 1)
);

    logic [NBIT-1:0] In;
    logic            load;
    logic            clr;
    logic            sl;
    logic            sr;
    logic            shiftIn;
    logic [1:0]      mode;
    logic            start;
    logic            dir;
    logic [AW-1:0]   amt;
    logic [NBIT-1:0] out;
    logic            shift_out;
    logic            busy;
    logic            done;

    modport master (
        output In, load, clr, sl, sr, shiftIn, mode, start, dir, amt,
        input  out, shift_out, busy, done
    );

    modport slave (
        input  In, load, clr, sl, sr, shiftIn, mode, start, dir, amt,
        output out, shift_out, busy, done
    );

endinterface

// File: rtl/multi_shift_reg_step.sv
// -----------------------------------------------------------------------------
// shift_step
// Combinational one-position shift; the only place the fill-bit rules live.
//   in      : current register value
//   dir     : 0 left, 1 right
//   mode    : logical / arithmetic / rotate (2'b11 as logical)
//   shiftIn : serial fill bit for logical mode
//   next    : shifted value
//   bit_out : bit pushed out of the register
// -----------------------------------------------------------------------------
module shift_step
    import shift_pkg::*;
#(
    parameter int NBIT = 16
) (
    input  logic [NBIT-1:0] in,
    input  logic            dir,
    input  logic [1:0]      mode,
    input  logic            shiftIn,
    output logic [NBIT-1:0] next,
    output logic            bit_out
);

    logic w_b;

    always_comb begin
        w_b     = shiftIn;
        next    = in;
        bit_out = 1'b0;
        if (!dir) begin
            case (mode)
                MODE_ARI: w_b = 1'b0;
                MODE_ROT: w_b = in[NBIT-1];
                default:  w_b = shiftIn;
            endcase
            next    = {in[NBIT-2:0], w_b};
            bit_out = in[NBIT-1];
        end else begin
            case (mode)
                MODE_ARI: w_b = in[NBIT-1];
                MODE_ROT: w_b = in[0];
                default:  w_b = shiftIn;
            endcase
            next    = {w_b, in[NBIT-1:1]};
            bit_out = in[0];
        end
    end

endmodule

// File: rtl/multi_shift_reg.sv
// -----------------------------------------------------------------------------
// multi_shift_reg
// Shift register with single-step sl/sr shifting and a multi-step shift-by-N
// engine (start/busy/done). All state changes on the falling clock edge.
//   clk   : clock (negedge active)
//   clr_n : asynchronous active-low reset
//   bus   : multi_shift_reg_if.slave (load/clear/shift controls, out,
//           shift_out, busy, done)
// Edge priority: clr > load > start > sl > sr > hold; while busy only clr
// is honoured.
// -----------------------------------------------------------------------------
module multi_shift_reg
    import shift_pkg::*;
#(
    parameter int NBIT = 16,
    parameter int AW   = $clog2(NBIT + 1)
) (
    input logic             clk,
    input logic             clr_n,
    multi_shift_reg_if.slave bus
);

    localparam logic [AW-1:0] NBIT_AMT = AW'(NBIT);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [NBIT-1:0] r_out;
    logic            r_shift_out;
    logic            r_done;
    logic            r_dir;
    logic [1:0]      r_mode;
    logic [AW-1:0]   r_count;

    logic            w_busy;
    logic            w_step_dir;
    logic [1:0]      w_step_mode;
    logic [NBIT-1:0] w_step_next;
    logic            w_step_bit;
    logic [AW-1:0]   w_amt_clamped;

    assign w_busy        = (r_state == S_SHIFT);
    assign w_amt_clamped = (bus.amt > NBIT_AMT) ? NBIT_AMT : bus.amt;

    // One shared step unit: the engine uses its latched dir/mode, otherwise
    // the single-step controls drive it (sl beats sr, so dir = ~sl).
    assign w_step_dir  = w_busy ? r_dir  : ~bus.sl;
    assign w_step_mode = w_busy ? r_mode : bus.mode;

    shift_step #(.NBIT(NBIT)) u_step (
        .in      (r_out),
        .dir     (w_step_dir),
        .mode    (w_step_mode),
        .shiftIn (bus.shiftIn),
        .next    (w_step_next),
        .bit_out (w_step_bit)
    );

    // State register
    always_ff @(negedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (bus.clr) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!bus.load && bus.start && (bus.amt != '0)) begin
                        w_state_nxt = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (r_count == AW'(1)) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Datapath: register, count, captured bit and the done pulse
    always_ff @(negedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_out       <= '0;
            r_shift_out <= 1'b0;
            r_done      <= 1'b0;
            r_dir       <= 1'b0;
            r_mode      <= MODE_LOG;
            r_count     <= '0;
        end else if (bus.clr) begin
            r_out       <= '0;
            r_shift_out <= 1'b0;
            r_done      <= 1'b0;
            r_count     <= '0;
        end else if (w_busy) begin
            r_out       <= w_step_next;
            r_shift_out <= w_step_bit;
            r_count     <= r_count - AW'(1);
            r_done      <= (r_count == AW'(1));
        end else begin
            r_done <= 1'b0;
            if (bus.load) begin
                r_out <= bus.In;
            end else if (bus.start) begin
                // A zero-length request completes immediately without
                // entering SHIFT.
                if (bus.amt == '0) begin
                    r_done <= 1'b1;
                end else begin
                    r_dir   <= bus.dir;
                    r_mode  <= bus.mode;
                    r_count <= w_amt_clamped;
                end
            end else if (bus.sl || bus.sr) begin
                r_out       <= w_step_next;
                r_shift_out <= w_step_bit;
            end
        end
    end

    // Outputs
    always_comb begin
        bus.out       = r_out;
        bus.shift_out = r_shift_out;
        bus.busy      = w_busy;
        bus.done      = r_done;
    end

endmodule

// File: tb/tb_multi_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_multi_shift_reg
// Scoreboard bench for multi_shift_reg: expectations are queued when stimulus
// is applied and compared just after the following falling edge.
// -----------------------------------------------------------------------------
module tb_multi_shift_reg;

    import shift_pkg::*;

    localparam int NBIT = 16;
    localparam int AW   = $clog2(NBIT + 1);

    logic clk = 1'b0;
    logic clr_n;

    multi_shift_reg_if #(.NBIT(NBIT), .AW(AW)) bus ();

    multi_shift_reg #(.NBIT(NBIT), .AW(AW)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef enum int {SIG_OUT, SIG_SO, SIG_BUSY, SIG_DONE} sig_e;
    typedef struct {
        string       tag;
        sig_e        sig;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [15:0] m_out;
    logic        m_so;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic expect_sig(input string tag, input sig_e s, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sig = s;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic expect_all(input string tag, input logic [15:0] o, input logic so,
                              input logic b, input logic d);
        expect_sig({tag, "_out"},  SIG_OUT,  {16'h0, o});
        expect_sig({tag, "_so"},   SIG_SO,   {31'h0, so});
        expect_sig({tag, "_busy"}, SIG_BUSY, {31'h0, b});
        expect_sig({tag, "_done"}, SIG_DONE, {31'h0, d});
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] act;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sig)
                SIG_OUT:  act = {16'h0, bus.out};
                SIG_SO:   act = {31'h0, bus.shift_out};
                SIG_BUSY: act = {31'h0, bus.busy};
                default:  act = {31'h0, bus.done};
            endcase
            chk_val(e.tag, act, e.val);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
        drain();
    endtask

    function automatic logic [16:0] mstep(input logic [15:0] v, input logic d,
                                          input logic [1:0] m, input logic si);
        logic b;
        if (!d) begin
            b = (m == 2'b01) ? 1'b0 : (m == 2'b10) ? v[15] : si;
            return {v[15], v[14:0], b};
        end
        b = (m == 2'b01) ? v[15] : (m == 2'b10) ? v[0] : si;
        return {v[0], b, v[15:1]};
    endfunction

    task automatic model_step(input logic d, input logic [1:0] m);
        {m_so, m_out} = mstep(m_out, d, m, bus.shiftIn);
    endtask

    task automatic idle();
        bus.load  = 1'b0;
        bus.clr   = 1'b0;
        bus.sl    = 1'b0;
        bus.sr    = 1'b0;
        bus.start = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] v);
        idle();
        bus.load = 1'b1;
        bus.In   = v;
        m_out    = v;
        expect_sig("load_out", SIG_OUT, {16'h0, v});
        tick();
        bus.load = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic       d;
        clr_n     = 1'b1;
        bus.In    = '0;
        bus.mode  = MODE_LOG;
        bus.shiftIn = 1'b0;
        bus.dir   = 1'b0;
        bus.amt   = '0;
        idle();
        #1 clr_n = 1'b0;
        #2;
        expect_all("reset", 16'h0, 1'b0, 1'b0, 1'b0);
        drain();
        #1 clr_n = 1'b1;
        m_out = '0;
        m_so  = 1'b0;

        // Load then logical left with shiftIn=1
        do_load(16'hA5F0);
        bus.sl = 1'b1; bus.mode = MODE_LOG; bus.shiftIn = 1'b1;
        model_step(1'b0, MODE_LOG);
        expect_sig("sl_log_out", SIG_OUT, 32'h4BE1);
        expect_sig("sl_log_so",  SIG_SO,  32'h1);
        tick();

        // Arithmetic then rotate right
        do_load(16'h8004);
        bus.sr = 1'b1; bus.mode = MODE_ARI;
        model_step(1'b1, MODE_ARI);
        expect_sig("sr_ari_out", SIG_OUT, 32'hC002);
        expect_sig("sr_ari_so",  SIG_SO,  32'h0);
        tick();
        bus.mode = MODE_ROT;
        model_step(1'b1, MODE_ROT);
        expect_sig("sr_rot_out", SIG_OUT, 32'h6001);
        expect_sig("sr_rot_so",  SIG_SO,  32'h0);
        tick();

        // sl and sr together: left wins
        bus.sl = 1'b1; bus.sr = 1'b1; bus.mode = MODE_LOG; bus.shiftIn = 1'b0;
        model_step(1'b0, MODE_LOG);
        expect_all("sl_sr_both", m_out, m_so, 1'b0, 1'b0);
        tick();

        // Hold with no controls
        idle();
        expect_all("hold", m_out, m_so, 1'b0, 1'b0);
        tick();

        // Random single steps across all modes
        for (int i = 0; i < 24; i++) begin
            idle();
            d           = 1'($urandom_range(0, 1));
            bus.mode    = 2'($urandom_range(0, 3));
            bus.shiftIn = 1'($urandom_range(0, 1));
            if (d) bus.sr = 1'b1;
            else   bus.sl = 1'b1;
            model_step(d, bus.mode);
            expect_sig("rand_out", SIG_OUT, {16'h0, m_out});
            expect_sig("rand_so",  SIG_SO,  {31'h0, m_so});
            tick();
        end

        // Rotate left by 4, with a load attempted mid-shift
        do_load(16'h00FF);
        bus.start = 1'b1; bus.dir = 1'b0; bus.amt = 5'd4; bus.mode = MODE_ROT;
        expect_all("rot4_start", m_out, m_so, 1'b1, 1'b0);
        tick();
        bus.start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            bus.load = (k == 2);
            bus.In   = 16'hFFFF;
            model_step(1'b0, MODE_ROT);
            expect_all("rot4_step", m_out, m_so, k < 4, k == 4);
            if (k == 4) expect_sig("rot4_final", SIG_OUT, 32'h0FF0);
            tick();
        end
        idle();
        expect_all("rot4_after", m_out, m_so, 1'b0, 1'b0);
        tick();

        // Zero-length request
        bus.start = 1'b1; bus.amt = '0;
        expect_all("amt0", m_out, m_so, 1'b0, 1'b1);
        tick();
        idle();
        expect_all("amt0_after", m_out, m_so, 1'b0, 1'b0);
        tick();

        // amt=31 clamps to 16 logical right steps with shiftIn=0
        do_load(16'hBEEF);
        bus.start = 1'b1; bus.dir = 1'b1; bus.amt = 5'd31;
        bus.mode = MODE_LOG; bus.shiftIn = 1'b0;
        expect_all("clamp_start", m_out, m_so, 1'b1, 1'b0);
        tick();
        bus.start = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            model_step(1'b1, MODE_LOG);
            expect_all("clamp_step", m_out, m_so, k < 16, k == 16);
            if (k == 16) expect_sig("clamp_final", SIG_OUT, 32'h0);
            tick();
        end
        expect_all("clamp_after", m_out, m_so, 1'b0, 1'b0);
        tick();

        // Same request aborted by clr on step 3
        do_load(16'hBEEF);
        bus.start = 1'b1;
        expect_all("abort_start", m_out, m_so, 1'b1, 1'b0);
        tick();
        bus.start = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            model_step(1'b1, MODE_LOG);
            expect_all("abort_step", m_out, m_so, 1'b1, 1'b0);
            tick();
        end
        bus.clr = 1'b1;
        m_out = '0; m_so = 1'b0;
        expect_all("abort_clr", 16'h0, 1'b0, 1'b0, 1'b0);
        tick();
        bus.clr = 1'b0;
        for (int k = 0; k < 17; k++) begin
            expect_sig("abort_no_done", SIG_DONE, 32'h0);
            expect_sig("abort_no_busy", SIG_BUSY, 32'h0);
            tick();
        end

        // start held through completion re-triggers on the edge after IDLE
        do_load(16'h1234);
        bus.start = 1'b1; bus.dir = 1'b0; bus.amt = 5'd2;
        bus.mode = MODE_LOG; bus.shiftIn = 1'b1;
        for (int e = 0; e < 6; e++) begin
            if (e == 4) bus.start = 1'b0;
            if (e == 1 || e == 2 || e == 4 || e == 5) model_step(1'b0, MODE_LOG);
            expect_all("retrig", m_out, m_so,
                       (e == 0 || e == 1 || e == 3 || e == 4), (e == 2 || e == 5));
            tick();
        end

        // Asynchronous reset in the middle of a shift
        do_load(16'hABCD);
        bus.start = 1'b1; bus.dir = 1'b1; bus.amt = 5'd8;
        tick();
        bus.start = 1'b0;
        model_step(1'b1, MODE_LOG);
        expect_all("pre_async", m_out, m_so, 1'b1, 1'b0);
        tick();
        @(posedge clk);
        #1 clr_n = 1'b0;
        #1;
        expect_all("async_rst", 16'h0, 1'b0, 1'b0, 1'b0);
        drain();
        #1 clr_n = 1'b1;
        m_out = '0; m_so = 1'b0;
        expect_all("post_async", 16'h0, 1'b0, 1'b0, 1'b0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
